// File: rtl/cbr_ts_pkt_buffer.sv
// rtl/cbr_ts_pkt_buffer.sv - packet-aware CBR TS byte buffer with null-packet insertion
module cbr_ts_pkt_buffer #(
    parameter int ADDR_W               = 12,
    parameter int PKT_LEN              = 188,
    parameter int PROG_FULL_THRESHOLD  = 3859,
    parameter int PROG_EMPTY_THRESHOLD = 188,
    parameter int NULL_INSERT          = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              wr_en,
    input  logic              wr_sop,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              dout_sop,
    output logic              dout_null,
    output logic [ADDR_W:0]   data_count,
    output logic [ADDR_W:0]   pkt_count,
    output logic              full,
    output logic              prog_full,
    output logic              prog_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       null_cnt
);
    localparam int              PW    = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = PW'(1);
    localparam logic [ADDR_W:0] PF_TH = PW'(PROG_FULL_THRESHOLD);
    localparam logic [ADDR_W:0] PE_TH = PW'(PROG_EMPTY_THRESHOLD);
    localparam logic [7:0]      LAST  = 8'(PKT_LEN - 1);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_PKT, R_NULL} rstate_t;

    logic [7:0] mem [2**ADDR_W];

    wstate_t         wstate, wstate_n;
    rstate_t         rstate, rstate_n;
    logic [7:0]      widx, widx_n, ridx, ridx_n;
    logic [ADDR_W:0] wr_ptr, wr_ptr_n, wr_cmt, wr_cmt_n, rd_ptr, rd_ptr_n;
    logic [ADDR_W:0] pkt_count_n, dc_n, cmt_n;
    logic            orphan, orphan_n;
    logic            commit, start, null_start, drop, ovf, unf;
    logic            mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]      dout_n;
    logic            valid_n, sop_n, null_n;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    null_byte = 8'h47;
            8'd1:    null_byte = 8'h1F;
            8'd2:    null_byte = 8'hFF;
            8'd3:    null_byte = 8'h10;
            default: null_byte = 8'hFF;
        endcase
    endfunction

    assign data_count = wr_ptr - rd_ptr;
    assign full       = (data_count == DEPTH);

    // Write side: bytes land at wr_ptr but only become readable once wr_cmt moves.
    always_comb begin
        wstate_n  = wstate;
        widx_n    = widx;
        wr_ptr_n  = wr_ptr;
        wr_cmt_n  = wr_cmt;
        orphan_n  = orphan;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr[ADDR_W-1:0];
        commit    = 1'b0;
        drop      = 1'b0;
        ovf       = 1'b0;
        if (wr_en) begin
            if (wstate == W_IDLE && !wr_sop) begin
                // Tail of an overflowed packet is already counted; only fresh runs count.
                drop     = !orphan;
                orphan_n = 1'b1;
            end else if (full) begin
                ovf      = 1'b1;
                drop     = 1'b1;
                wr_ptr_n = wr_cmt;
                wstate_n = W_IDLE;
                orphan_n = 1'b1;
            end else if (wr_sop) begin
                drop      = (wstate == W_FILL);
                mem_we    = 1'b1;
                mem_waddr = wr_cmt[ADDR_W-1:0];
                wr_ptr_n  = wr_cmt + ONE;
                widx_n    = 8'd1;
                wstate_n  = W_FILL;
                orphan_n  = 1'b0;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_n = wr_ptr + ONE;
                widx_n   = widx + 8'd1;
                if (widx == LAST) begin
                    commit   = 1'b1;
                    wr_cmt_n = wr_ptr + ONE;
                    wstate_n = W_IDLE;
                    widx_n   = 8'd0;
                end
            end
        end
    end

    always_comb begin
        rstate_n   = rstate;
        ridx_n     = ridx;
        rd_ptr_n   = rd_ptr;
        start      = 1'b0;
        null_start = 1'b0;
        unf        = 1'b0;
        dout_n     = dout;
        valid_n    = 1'b0;
        sop_n      = 1'b0;
        null_n     = 1'b0;
        if (rd_en) begin
            case (rstate)
                R_IDLE: begin
                    if (pkt_count != '0) begin
                        start    = 1'b1;
                        rstate_n = R_PKT;
                        dout_n   = mem[rd_ptr[ADDR_W-1:0]];
                        rd_ptr_n = rd_ptr + ONE;
                        ridx_n   = 8'd1;
                        valid_n  = 1'b1;
                        sop_n    = 1'b1;
                    end else if (NULL_INSERT != 0) begin
                        null_start = 1'b1;
                        rstate_n   = R_NULL;
                        dout_n     = null_byte(8'd0);
                        ridx_n     = 8'd1;
                        valid_n    = 1'b1;
                        sop_n      = 1'b1;
                        null_n     = 1'b1;
                    end else begin
                        unf = 1'b1;
                    end
                end
                R_PKT: begin
                    dout_n   = mem[rd_ptr[ADDR_W-1:0]];
                    rd_ptr_n = rd_ptr + ONE;
                    valid_n  = 1'b1;
                    ridx_n   = ridx + 8'd1;
                    if (ridx == LAST) begin
                        rstate_n = R_IDLE;
                        ridx_n   = 8'd0;
                    end
                end
                R_NULL: begin
                    dout_n  = null_byte(ridx);
                    valid_n = 1'b1;
                    null_n  = 1'b1;
                    ridx_n  = ridx + 8'd1;
                    if (ridx == LAST) begin
                        rstate_n = R_IDLE;
                        ridx_n   = 8'd0;
                    end
                end
                default: rstate_n = R_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_count_n = pkt_count;
        case ({commit, start})
            2'b10:   pkt_count_n = pkt_count + ONE;
            2'b01:   pkt_count_n = pkt_count - ONE;
            default: pkt_count_n = pkt_count;
        endcase
        dc_n  = wr_ptr_n - rd_ptr_n;
        cmt_n = wr_cmt_n - rd_ptr_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate     <= W_IDLE;
            rstate     <= R_IDLE;
            widx       <= 8'd0;
            ridx       <= 8'd0;
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            rd_ptr     <= '0;
            orphan     <= 1'b0;
            pkt_count  <= '0;
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_null  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            drop_cnt   <= 16'd0;
            null_cnt   <= 16'd0;
        end else begin
            wstate     <= wstate_n;
            rstate     <= rstate_n;
            widx       <= widx_n;
            ridx       <= ridx_n;
            wr_ptr     <= wr_ptr_n;
            wr_cmt     <= wr_cmt_n;
            rd_ptr     <= rd_ptr_n;
            orphan     <= orphan_n;
            pkt_count  <= pkt_count_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            dout_sop   <= sop_n;
            dout_null  <= null_n;
            overflow   <= ovf;
            underflow  <= unf;
            prog_full  <= (dc_n == DEPTH) || (dc_n > PF_TH);
            prog_empty <= (cmt_n < PE_TH);
            if (drop && drop_cnt != 16'hFFFF)       drop_cnt <= drop_cnt + 16'd1;
            if (null_start && null_cnt != 16'hFFFF) null_cnt <= null_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_cbr_ts_pkt_buffer.sv
// tb/tb_cbr_ts_pkt_buffer.sv - directed self-checking bench for cbr_ts_pkt_buffer
module tb_cbr_ts_pkt_buffer;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic wr_en = 1'b0, wr_sop = 1'b0, rd_en = 1'b0;

    logic [7:0]  a_dout, b_dout;
    logic        a_dout_valid, a_dout_sop, a_dout_null, b_dout_valid, b_dout_sop, b_dout_null;
    logic [10:0] a_data_count, a_pkt_count;
    logic [12:0] b_data_count, b_pkt_count;
    logic        a_full, a_prog_full, a_prog_empty, a_overflow, a_underflow;
    logic        b_full, b_prog_full, b_prog_empty, b_overflow, b_underflow;
    logic [15:0] a_drop_cnt, a_null_cnt, b_drop_cnt, b_null_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    cbr_ts_pkt_buffer #(.ADDR_W(10), .PKT_LEN(188), .PROG_FULL_THRESHOLD(950),
                        .PROG_EMPTY_THRESHOLD(188), .NULL_INSERT(1)) dut_a (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .wr_sop(wr_sop), .rd_en(rd_en),
        .dout(a_dout), .dout_valid(a_dout_valid), .dout_sop(a_dout_sop), .dout_null(a_dout_null),
        .data_count(a_data_count), .pkt_count(a_pkt_count), .full(a_full),
        .prog_full(a_prog_full), .prog_empty(a_prog_empty), .overflow(a_overflow),
        .underflow(a_underflow), .drop_cnt(a_drop_cnt), .null_cnt(a_null_cnt));

    cbr_ts_pkt_buffer #(.NULL_INSERT(0)) dut_b (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .wr_sop(wr_sop), .rd_en(rd_en),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_sop(b_dout_sop), .dout_null(b_dout_null),
        .data_count(b_data_count), .pkt_count(b_pkt_count), .full(b_full),
        .prog_full(b_prog_full), .prog_empty(b_prog_empty), .overflow(b_overflow),
        .underflow(b_underflow), .drop_cnt(b_drop_cnt), .null_cnt(b_null_cnt));

    always #5 clk = ~clk;

    task automatic cyc(input logic w, input logic [7:0] d, input logic s, input logic r);
        @(negedge clk);
        wr_en = w; din = d; wr_sop = s; rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_sop = 1'b0; rd_en = 1'b0;
    endtask

    function automatic logic [7:0] null_exp(input int i);
        case (i)
            0: null_exp = 8'h47;
            1: null_exp = 8'h1F;
            2: null_exp = 8'hFF;
            3: null_exp = 8'h10;
            default: null_exp = 8'hFF;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (a_dout !== 8'd0) $display("FAIL reset_dout got %h exp 00", a_dout); else pass_cnt++;
        total_cnt++; if ({a_dout_valid, a_dout_sop, a_dout_null} !== 3'b000) $display("FAIL reset_strobes got %b exp 000", {a_dout_valid, a_dout_sop, a_dout_null}); else pass_cnt++;
        total_cnt++; if ({a_full, a_prog_full, a_prog_empty, a_overflow, a_underflow} !== 5'b00100) $display("FAIL reset_flags got %b exp 00100", {a_full, a_prog_full, a_prog_empty, a_overflow, a_underflow}); else pass_cnt++;
        total_cnt++; if (a_data_count !== 11'd0 || a_pkt_count !== 11'd0) $display("FAIL reset_counts got dc=%0d pc=%0d exp 0/0", a_data_count, a_pkt_count); else pass_cnt++;
        total_cnt++; if (a_drop_cnt !== 16'd0 || a_null_cnt !== 16'd0) $display("FAIL reset_stats got drop=%0d null=%0d exp 0/0", a_drop_cnt, a_null_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_null_insert();
        for (int i = 0; i < 188; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            total_cnt++; if (a_dout !== null_exp(i)) $display("FAIL null_byte[%0d] got %h exp %h", i, a_dout, null_exp(i)); else pass_cnt++;
            total_cnt++; if ({a_dout_valid, a_dout_null, a_dout_sop} !== {2'b11, i == 0}) $display("FAIL null_flags[%0d] got %b exp %b", i, {a_dout_valid, a_dout_null, a_dout_sop}, {2'b11, i == 0}); else pass_cnt++;
            total_cnt++; if ({b_underflow, b_dout_valid} !== 2'b10) $display("FAIL underflow[%0d] got %b exp 10", i, {b_underflow, b_dout_valid}); else pass_cnt++;
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        total_cnt++; if (a_dout_valid !== 1'b0 || b_underflow !== 1'b0) $display("FAIL null_idle got v=%b u=%b exp 0/0", a_dout_valid, b_underflow); else pass_cnt++;
        total_cnt++; if (a_null_cnt !== 16'd1) $display("FAIL null_cnt got %0d exp 1", a_null_cnt); else pass_cnt++;
    endtask

    task automatic test_single_pkt();
        for (int i = 0; i < 188; i++) cyc(1'b1, 8'(i), i == 0, 1'b0);
        total_cnt++; if (a_pkt_count !== 11'd1 || a_data_count !== 11'd188) $display("FAIL single_stored got pc=%0d dc=%0d exp 1/188", a_pkt_count, a_data_count); else pass_cnt++;
        total_cnt++; if (a_prog_empty !== 1'b0) $display("FAIL single_prog_empty got %b exp 0", a_prog_empty); else pass_cnt++;
        for (int i = 0; i < 188; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            total_cnt++; if (a_dout !== 8'(i)) $display("FAIL single_byte[%0d] got %h exp %h", i, a_dout, 8'(i)); else pass_cnt++;
            total_cnt++; if ({a_dout_valid, a_dout_sop, a_dout_null} !== {1'b1, i == 0, 1'b0}) $display("FAIL single_flags[%0d] got %b exp %b", i, {a_dout_valid, a_dout_sop, a_dout_null}, {1'b1, i == 0, 1'b0}); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (a_pkt_count !== 11'd0) $display("FAIL single_pkt_dec got %0d exp 0", a_pkt_count); else pass_cnt++;
            end
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        total_cnt++; if (a_dout_valid !== 1'b0 || a_data_count !== 11'd0 || a_prog_empty !== 1'b1) $display("FAIL single_drained got v=%b dc=%0d pe=%b exp 0/0/1", a_dout_valid, a_data_count, a_prog_empty); else pass_cnt++;
    endtask

    task automatic test_short_pkt();
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i + 50), i == 0, 1'b0);
        for (int i = 0; i < 188; i++) cyc(1'b1, 8'(i * 3), i == 0, 1'b0);
        total_cnt++; if (a_drop_cnt !== 16'd1 || a_pkt_count !== 11'd1 || a_data_count !== 11'd188) $display("FAIL short_state got drop=%0d pc=%0d dc=%0d exp 1/1/188", a_drop_cnt, a_pkt_count, a_data_count); else pass_cnt++;
        for (int i = 0; i < 188; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            total_cnt++; if (a_dout !== 8'(i * 3) || a_dout_valid !== 1'b1) $display("FAIL short_byte[%0d] got %h v=%b exp %h v=1", i, a_dout, a_dout_valid, 8'(i * 3)); else pass_cnt++;
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        total_cnt++; if (a_pkt_count !== 11'd0 || a_data_count !== 11'd0) $display("FAIL short_drained got pc=%0d dc=%0d exp 0/0", a_pkt_count, a_data_count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 188; i++) cyc(1'b1, 8'(k * 16 + i), i == 0, 1'b0);
        total_cnt++; if (a_pkt_count !== 11'd5 || a_data_count !== 11'd940 || a_prog_full !== 1'b0 || a_full !== 1'b0) $display("FAIL ovf_five got pc=%0d dc=%0d pf=%b f=%b exp 5/940/0/0", a_pkt_count, a_data_count, a_prog_full, a_full); else pass_cnt++;
        for (int i = 0; i < 188; i++) begin
            cyc(1'b1, 8'(i), i == 0, 1'b0);
            if (i == 9) begin
                total_cnt++; if (a_data_count !== 11'd950 || a_prog_full !== 1'b0) $display("FAIL ovf_pf_at_950 got dc=%0d pf=%b exp 950/0", a_data_count, a_prog_full); else pass_cnt++;
            end
            if (i == 10) begin
                total_cnt++; if (a_prog_full !== 1'b1) $display("FAIL ovf_pf_at_951 got %b exp 1", a_prog_full); else pass_cnt++;
            end
            if (i == 83) begin
                total_cnt++; if (a_data_count !== 11'd1024 || a_full !== 1'b1 || a_prog_full !== 1'b1 || a_overflow !== 1'b0) $display("FAIL ovf_full got dc=%0d f=%b pf=%b o=%b exp 1024/1/1/0", a_data_count, a_full, a_prog_full, a_overflow); else pass_cnt++;
            end
            if (i == 84) begin
                total_cnt++; if (a_overflow !== 1'b1 || a_drop_cnt !== 16'd2 || a_data_count !== 11'd940 || a_prog_full !== 1'b0) $display("FAIL ovf_pulse got o=%b drop=%0d dc=%0d pf=%b exp 1/2/940/0", a_overflow, a_drop_cnt, a_data_count, a_prog_full); else pass_cnt++;
            end
            if (i == 85) begin
                total_cnt++; if (a_overflow !== 1'b0) $display("FAIL ovf_one_cycle got %b exp 0", a_overflow); else pass_cnt++;
            end
        end
        total_cnt++; if (a_drop_cnt !== 16'd2 || a_pkt_count !== 11'd5 || a_data_count !== 11'd940) $display("FAIL ovf_after got drop=%0d pc=%0d dc=%0d exp 2/5/940", a_drop_cnt, a_pkt_count, a_data_count); else pass_cnt++;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 188; i++) begin
                cyc(1'b0, 8'd0, 1'b0, 1'b1);
                total_cnt++; if (a_dout !== 8'(k * 16 + i) || a_dout_sop !== (i == 0) || a_dout_null !== 1'b0) $display("FAIL ovf_drain[%0d][%0d] got %h sop=%b null=%b exp %h", k, i, a_dout, a_dout_sop, a_dout_null, 8'(k * 16 + i)); else pass_cnt++;
            end
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        total_cnt++; if (a_pkt_count !== 11'd0 || a_data_count !== 11'd0) $display("FAIL ovf_drained got pc=%0d dc=%0d exp 0/0", a_pkt_count, a_data_count); else pass_cnt++;
    endtask

    task automatic test_commit_collision();
        for (int i = 0; i < 187; i++) cyc(1'b1, 8'(255 - i), i == 0, 1'b0);
        cyc(1'b1, 8'(255 - 187), 1'b0, 1'b1);
        total_cnt++; if (a_dout !== 8'h47 || {a_dout_valid, a_dout_sop, a_dout_null} !== 3'b111) $display("FAIL coll_null_start got %h flags=%b exp 47/111", a_dout, {a_dout_valid, a_dout_sop, a_dout_null}); else pass_cnt++;
        total_cnt++; if (a_null_cnt !== 16'd2 || a_pkt_count !== 11'd1) $display("FAIL coll_counts got null=%0d pc=%0d exp 2/1", a_null_cnt, a_pkt_count); else pass_cnt++;
        for (int i = 1; i < 188; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            total_cnt++; if (a_dout !== null_exp(i) || a_dout_null !== 1'b1) $display("FAIL coll_null[%0d] got %h null=%b exp %h", i, a_dout, a_dout_null, null_exp(i)); else pass_cnt++;
        end
        for (int i = 0; i < 188; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            total_cnt++; if (a_dout !== 8'(255 - i) || a_dout_null !== 1'b0 || a_dout_sop !== (i == 0)) $display("FAIL coll_pkt[%0d] got %h null=%b sop=%b exp %h", i, a_dout, a_dout_null, a_dout_sop, 8'(255 - i)); else pass_cnt++;
        end
        total_cnt++; if (a_pkt_count !== 11'd0 || a_null_cnt !== 16'd2) $display("FAIL coll_end got pc=%0d null=%0d exp 0/2", a_pkt_count, a_null_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_pkt();
        for (int i = 0; i < 188; i++) cyc(1'b1, 8'(i + 1), i == 0, 1'b0);
        for (int i = 0; i <= 50; i++) cyc(1'b0, 8'd0, 1'b0, 1'b1);
        total_cnt++; if (a_dout !== 8'd51) $display("FAIL mid_byte50 got %h exp 33", a_dout); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++; if (a_dout !== 8'd0 || {a_dout_valid, a_dout_sop, a_dout_null} !== 3'b000) $display("FAIL mid_rst_out got %h flags=%b exp 00/000", a_dout, {a_dout_valid, a_dout_sop, a_dout_null}); else pass_cnt++;
        total_cnt++; if (a_pkt_count !== 11'd0 || a_data_count !== 11'd0 || a_prog_empty !== 1'b1) $display("FAIL mid_rst_counts got pc=%0d dc=%0d pe=%b exp 0/0/1", a_pkt_count, a_data_count, a_prog_empty); else pass_cnt++;
        total_cnt++; if (a_drop_cnt !== 16'd0 || a_null_cnt !== 16'd0) $display("FAIL mid_rst_stats got drop=%0d null=%0d exp 0/0", a_drop_cnt, a_null_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        total_cnt++; if (a_dout !== 8'h47 || {a_dout_valid, a_dout_sop, a_dout_null} !== 3'b111 || a_null_cnt !== 16'd1) $display("FAIL mid_post_null got %h flags=%b null=%0d exp 47/111/1", a_dout, {a_dout_valid, a_dout_sop, a_dout_null}, a_null_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_null_insert();
        test_single_pkt();
        test_short_pkt();
        test_overflow();
        test_commit_collision();
        test_reset_mid_pkt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
